// File: rtl/nbit_piso_shifter_if.sv
// Handshake bundle for the PISO transmitter: parallel word in, serial bits out.
// The slave modport is the shifter; master is the word source plus serial sink.
interface nbit_piso_shifter_if #(
    parameter int n = 32
);
    logic [n-1:0] ino;
    logic         in_valid;
    logic         in_ready;
    logic         sout;
    logic         sout_valid;
    logic         sout_ready;
    logic         sout_last;
    logic         busy;

    modport slave (
        input  ino,
        input  in_valid,
        output in_ready,
        output sout,
        output sout_valid,
        input  sout_ready,
        output sout_last,
        output busy
    );

    modport master (
        output ino,
        output in_valid,
        input  in_ready,
        input  sout,
        input  sout_valid,
        output sout_ready,
        input  sout_last,
        input  busy
    );
endinterface

// File: rtl/nbit_piso_shifter.sv
// Parallel-in/serial-out transmitter: takes one n-bit word per handshake and
// emits it one bit per accepted serial beat, flagging the final bit.
module nbit_piso_shifter #(
    parameter int n         = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    nbit_piso_shifter_if.slave    bus
);
    localparam int CW = $clog2(n);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          r_state, w_state_next;
    logic [n-1:0]    r_shreg, w_shreg_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic [n-1:0]    w_shifted;
    logic            w_out_bit;
    logic            w_last;
    logic            w_in_ready;

    // Shift toward the output end with zero fill; the output end depends on bit order.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_shreg[n-2:0], 1'b0};
            assign w_out_bit = r_shreg[n-1];
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, r_shreg[n-1:1]};
            assign w_out_bit = r_shreg[0];
        end
    endgenerate

    assign w_last     = (r_state == SHIFT) && (r_cnt == CW'(n - 1));
    // Ready on the last beat lets the next word follow with no idle bubble.
    assign w_in_ready = (r_state == IDLE) | (w_last & bus.sout_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_shreg <= w_shreg_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shreg_next = r_shreg;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_shreg_next = bus.ino;
                    w_cnt_next   = '0;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.sout_ready) begin
                    if (w_last) begin
                        if (bus.in_valid) begin
                            w_shreg_next = bus.ino;
                            w_cnt_next   = '0;
                        end else begin
                            w_shreg_next = w_shifted;
                            w_cnt_next   = '0;
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_shreg_next = w_shifted;
                        w_cnt_next   = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.sout_valid = (r_state == SHIFT);
    assign bus.busy       = (r_state == SHIFT);
    assign bus.sout_last  = w_last;
    assign bus.sout       = (r_state == SHIFT) ? w_out_bit : 1'b0;
endmodule

// File: tb/tb_nbit_piso_shifter.sv
// Directed bench for nbit_piso_shifter at n=8: LSB-first and MSB-first instances
// sharing clock and reset, one line per transaction.
module tb_nbit_piso_shifter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    nbit_piso_shifter_if #(.n(8)) bus_a ();
    nbit_piso_shifter_if #(.n(8)) bus_b ();

    nbit_piso_shifter #(.n(8), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    nbit_piso_shifter #(.n(8), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Load a word into instance a (use_b=0) or b (use_b=1) and check every bit.
    // seq lists the expected bits in emission order; stall_at>=0 withholds
    // sout_ready for stall_n cycles while that bit is presented.
    task automatic send_word(input bit use_b, input logic [7:0] word, input logic [0:7] seq,
                             input int stall_at, input int stall_n, input string tag);
        logic s, v, l, r, b;
        @(negedge clk);
        if (use_b) begin
            bus_b.ino = word; bus_b.in_valid = 1'b1; bus_b.sout_ready = 1'b1;
        end else begin
            bus_a.ino = word; bus_a.in_valid = 1'b1; bus_a.sout_ready = 1'b1;
        end
        #1;
        r = use_b ? bus_b.in_ready : bus_a.in_ready;
        check({tag, "_load_rdy"}, {31'd0, r}, 32'd1);
        @(negedge clk);
        if (use_b) bus_b.in_valid = 1'b0; else bus_a.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == stall_at) begin
                if (use_b) bus_b.sout_ready = 1'b0; else bus_a.sout_ready = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    #1;
                    s = use_b ? bus_b.sout      : bus_a.sout;
                    l = use_b ? bus_b.sout_last : bus_a.sout_last;
                    r = use_b ? bus_b.in_ready  : bus_a.in_ready;
                    check($sformatf("%s_stall%0d_bit", tag, k), {31'd0, s}, {31'd0, seq[i]});
                    check($sformatf("%s_stall%0d_last", tag, k), {31'd0, l}, 32'd0);
                    check($sformatf("%s_stall%0d_rdy", tag, k), {31'd0, r}, 32'd0);
                    @(negedge clk);
                end
                if (use_b) bus_b.sout_ready = 1'b1; else bus_a.sout_ready = 1'b1;
            end
            #1;
            s = use_b ? bus_b.sout       : bus_a.sout;
            v = use_b ? bus_b.sout_valid : bus_a.sout_valid;
            l = use_b ? bus_b.sout_last  : bus_a.sout_last;
            b = use_b ? bus_b.busy       : bus_a.busy;
            check($sformatf("%s_bit%0d", tag, i), {31'd0, s}, {31'd0, seq[i]});
            check($sformatf("%s_valid%0d", tag, i), {31'd0, v}, 32'd1);
            check($sformatf("%s_last%0d", tag, i), {31'd0, l}, (i == 7) ? 32'd1 : 32'd0);
            check($sformatf("%s_busy%0d", tag, i), {31'd0, b}, 32'd1);
            @(negedge clk);
        end
        #1;
        r = use_b ? bus_b.in_ready   : bus_a.in_ready;
        b = use_b ? bus_b.busy       : bus_a.busy;
        v = use_b ? bus_b.sout_valid : bus_a.sout_valid;
        check({tag, "_end_rdy"}, {31'd0, r}, 32'd1);
        check({tag, "_end_busy"}, {31'd0, b}, 32'd0);
        check({tag, "_end_valid"}, {31'd0, v}, 32'd0);
        $display("word %s: ino=%02h done, compared=%0d mismatched=%0d", tag, word, n_cmp, n_err);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus_a.ino = '0; bus_a.in_valid = 1'b0; bus_a.sout_ready = 1'b0;
        bus_b.ino = '0; bus_b.in_valid = 1'b0; bus_b.sout_ready = 1'b0;

        // 1: reset
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", {31'd0, bus_a.sout_valid}, 32'd0);
        check("rst_busy",  {31'd0, bus_a.busy},       32'd0);
        check("rst_rdy",   {31'd0, bus_a.in_ready},   32'd1);
        check("rst_sout",  {31'd0, bus_a.sout},       32'd0);
        check("rst_last",  {31'd0, bus_a.sout_last},  32'd0);
        check("rst_b_valid", {31'd0, bus_b.sout_valid}, 32'd0);
        rst = 1'b0;
        $display("reset: compared=%0d mismatched=%0d", n_cmp, n_err);

        // 2: LSB-first
        send_word(1'b0, 8'hA5, 8'b10100101, -1, 0, "lsb_a5");
        // 3: backpressure on bit 2
        send_word(1'b0, 8'h3C, 8'b00111100, 2, 3, "bp_3c");

        // 4: back-to-back FF then 00
        @(negedge clk);
        bus_a.ino = 8'hFF; bus_a.in_valid = 1'b1; bus_a.sout_ready = 1'b1;
        @(negedge clk);
        bus_a.ino = 8'h00;
        for (int i = 0; i < 16; i++) begin
            #1;
            check($sformatf("b2b_bit%0d", i),   {31'd0, bus_a.sout},       (i < 8) ? 32'd1 : 32'd0);
            check($sformatf("b2b_valid%0d", i), {31'd0, bus_a.sout_valid}, 32'd1);
            check($sformatf("b2b_last%0d", i),  {31'd0, bus_a.sout_last},
                  (i == 7 || i == 15) ? 32'd1 : 32'd0);
            if (i == 3) check("b2b_rdy_mid", {31'd0, bus_a.in_ready}, 32'd0);
            if (i == 7) check("b2b_rdy_last", {31'd0, bus_a.in_ready}, 32'd1);
            if (i == 8) bus_a.in_valid = 1'b0;
            @(negedge clk);
        end
        #1;
        check("b2b_end_valid", {31'd0, bus_a.sout_valid}, 32'd0);
        check("b2b_end_busy",  {31'd0, bus_a.busy},       32'd0);
        $display("b2b FF,00: compared=%0d mismatched=%0d", n_cmp, n_err);

        // 5: MSB-first
        send_word(1'b1, 8'h81, 8'b10000001, -1, 0, "msb_81");
        send_word(1'b1, 8'hC4, 8'b11000100, -1, 0, "msb_c4");

        // 6: mid-word reset on F0 after 3 beats
        @(negedge clk);
        bus_a.ino = 8'hF0; bus_a.in_valid = 1'b1; bus_a.sout_ready = 1'b1;
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("mrst_bit%0d", i), {31'd0, bus_a.sout}, 32'd0);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_valid", {31'd0, bus_a.sout_valid}, 32'd0);
        check("mrst_rdy",   {31'd0, bus_a.in_ready},   32'd1);
        check("mrst_busy",  {31'd0, bus_a.busy},       32'd0);
        $display("mid-word reset: compared=%0d mismatched=%0d", n_cmp, n_err);
        send_word(1'b0, 8'h0F, 8'b11110000, -1, 0, "post_rst_0f");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
